// File: rtl/oam_dma_if.sv
// Initiator-side data bus between the OAM DMA engine and the arbiter/responders.
// Latency: none, wires only.
// Backpressure: bus_gnt from the arbiter gates the initiator between bytes.
interface oam_dma_if;
   logic        bus_req;
   logic        bus_gnt;
   logic [15:0] m_addr;
   logic        m_rd;
   logic        m_wr;
   logic [7:0]  m_wdata;
   logic [7:0]  m_rdata;

   modport master (
      output bus_req,
      output m_addr,
      output m_rd,
      output m_wr,
      output m_wdata,
      input  bus_gnt,
      input  m_rdata
   );

   modport slave (
      input  bus_req,
      input  m_addr,
      input  m_rd,
      input  m_wr,
      input  m_wdata,
      output bus_gnt,
      output m_rdata
   );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {src_hi,8'h00} (echo-mapped) to OAM_BASE.
// Latency: 3 cycles per byte (READ/CAPTURE/WRITE), done pulses 482 cycles after the CPU write.
// Backpressure: bus_gnt sampled only at byte boundaries; macro OAM_DMA_RESTART_EN lets a CPU write restart a busy transfer.
module oam_dma #(
   parameter int          DMA_LEN  = 160,
   parameter logic [15:0] OAM_BASE = 16'hFE00
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          reg_wr,
   input  logic [7:0]    reg_wdata,
   output logic [7:0]    reg_rdata,
   oam_dma_if.master     bus,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_READ    = 3'd2,
      S_CAPTURE = 3'd3,
      S_WRITE   = 3'd4
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   state_t     r_state;
   state_t     w_next;
   logic [7:0] r_rdata;
   logic [7:0] r_src_hi;
   logic [7:0] r_i;
   logic [7:0] r_data;
   logic       r_done;
   logic [7:0] w_src_eff;
   logic       w_start;
   logic       w_restart;
   logic       w_last;

   assign w_start = reg_wr && (r_state == S_IDLE);
   assign w_last  = (r_i == LAST_IDX);

`ifdef OAM_DMA_RESTART_EN
   // A CPU write while busy abandons the current transfer and re-arms from byte 0.
   assign w_restart = reg_wr && (r_state != S_IDLE);
`else
   // Writes while busy only update the readback register.
   assign w_restart = 1'b0;
`endif

   // Echo RAM (0xE000-0xFFFF) aliases work RAM 0x2000 lower.
   assign w_src_eff = (r_src_hi >= 8'hE0) ? (r_src_hi - 8'h20) : r_src_hi;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; a grant loss is only acted on after a completed WRITE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (reg_wr) w_next = S_REQ;
         S_REQ:     if (bus.bus_gnt) w_next = S_READ;
         S_READ:    w_next = S_CAPTURE;
         S_CAPTURE: w_next = S_WRITE;
         S_WRITE: begin
            if (w_last)           w_next = S_IDLE;
            else if (bus.bus_gnt) w_next = S_READ;
            else                  w_next = S_REQ;
         end
         default:   w_next = S_IDLE;
      endcase
      if (w_restart) w_next = S_REQ;
   end

   // Bus outputs decoded purely from state so an async reset clears them at once.
   always_comb begin
      bus.bus_req = (r_state != S_IDLE);
      bus.m_rd    = (r_state == S_READ);
      bus.m_wr    = (r_state == S_WRITE);
      bus.m_addr  = 16'h0000;
      bus.m_wdata = 8'h00;
      busy        = (r_state != S_IDLE);
      if (r_state == S_READ) begin
         bus.m_addr = {w_src_eff, r_i};
      end else if (r_state == S_WRITE) begin
         bus.m_addr  = OAM_BASE + {8'h00, r_i};
         bus.m_wdata = r_data;
      end
   end

   // CPU-visible register and source latch; the source only changes when a transfer (re)starts.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdata  <= 8'h00;
         r_src_hi <= 8'h00;
      end else begin
         if (reg_wr) r_rdata <= reg_wdata;
         if (w_start || w_restart) r_src_hi <= reg_wdata;
      end
   end

   // Byte index: cleared on (re)start and after the last byte, advanced after each WRITE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_i <= 8'h00;
      end else if (w_start || w_restart) begin
         r_i <= 8'h00;
      end else if (r_state == S_WRITE) begin
         r_i <= w_last ? 8'h00 : (r_i + 8'h01);
      end
   end

   // Read data is valid during CAPTURE, one cycle after the read strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= 8'h00;
      end else if (r_state == S_CAPTURE) begin
         r_data <= bus.m_rdata;
      end
   end

   // Completion pulse follows the final WRITE, even if a restart is taken in that cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_WRITE) && w_last;
      end
   end

   assign reg_rdata = r_rdata;
   assign done      = r_done;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: memory/OAM responder, strobe monitor and a
// byte-level expectation model built from the source-mapping and timing rules.
module tb_oam_dma;
   logic       clk       = 1'b0;
   logic       reset_n   = 1'b0;
   logic       reg_wr    = 1'b0;
   logic [7:0] reg_wdata = 8'h00;
   logic [7:0] reg_rdata;
   logic       busy;
   logic       done;
   logic       gnt       = 1'b1;

   oam_dma_if bus_if();

   oam_dma dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .reg_wr    (reg_wr),
      .reg_wdata (reg_wdata),
      .reg_rdata (reg_rdata),
      .bus       (bus_if),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // Responder: 64 KiB memory for reads, 160-byte OAM window for writes.
   logic [7:0] mem [0:65535];
   logic [7:0] oam [0:159];
   logic [7:0] rdata_r = 8'h00;
   logic       clr_req = 1'b0;
   logic [7:0] clr_val = 8'h00;

   assign bus_if.m_rdata = rdata_r;
   assign bus_if.bus_gnt = gnt;

   always @(posedge clk) begin
      if (bus_if.m_rd) rdata_r <= mem[bus_if.m_addr];
      if (clr_req) begin
         for (int k = 0; k < 160; k++) oam[k] <= clr_val;
      end else if (bus_if.m_wr && bus_if.m_addr >= 16'hFE00 && bus_if.m_addr < 16'hFEA0) begin
         oam[int'(bus_if.m_addr) - 32'hFE00] <= bus_if.m_wdata;
      end
   end

   // Monitor, sampled on the falling edge.
   logic [15:0] rd_q[$];
   int          wr_q[$];
   int          strobe_q[$];
   int          done_q[$];

   always @(negedge clk) begin
      if (reset_n) begin
         if (bus_if.m_rd) begin
            rd_q.push_back(bus_if.m_addr);
            strobe_q.push_back(cyc);
         end
         if (bus_if.m_wr) begin
            wr_q.push_back(cyc);
            strobe_q.push_back(cyc);
         end
         if (done) done_q.push_back(cyc);
      end
   end

   // Reference: effective source page and expected OAM byte.
   function automatic logic [7:0] eff_src(input logic [7:0] s);
      logic [7:0] r;
      r = s;
      if (s >= 8'hE0) r = s - 8'h20;
      return r;
   endfunction

   function automatic logic [7:0] exp_byte(input logic [7:0] s, input int k);
      logic [15:0] a;
      a = {eff_src(s), 8'(k)};
      return mem[a];
   endfunction

   task automatic go_to(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic kick(input logic [7:0] v, output int n);
      reg_wdata = v;
      reg_wr    = 1'b1;
      n         = cyc;
      @(negedge clk);
      reg_wr    = 1'b0;
   endtask

   task automatic clear_oam(input logic [7:0] v);
      clr_val = v;
      clr_req = 1'b1;
      @(negedge clk);
      clr_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      checks++; if (reg_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", reg_rdata); end
      checks++; if (bus_if.bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_if.bus_req); end
      checks++; if (bus_if.m_addr !== 16'h0000) begin errors++; $display("FAIL reset_m_addr: got %h want 0000", bus_if.m_addr); end
      checks++; if (bus_if.m_rd !== 1'b0 || bus_if.m_wr !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0/0", bus_if.m_rd, bus_if.m_wr); end
      checks++; if (bus_if.m_wdata !== 8'h00) begin errors++; $display("FAIL reset_m_wdata: got %h want 00", bus_if.m_wdata); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b/%b want 0/0", busy, done); end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic;
      int n, d0, r0, w0;
      clear_oam(8'h00);
      d0 = done_q.size(); r0 = rd_q.size(); w0 = wr_q.size();
      kick(8'hC0, n);
      checks++; if (busy !== 1'b1 || bus_if.bus_req !== 1'b1) begin errors++; $display("FAIL basic_req_n1: got busy=%b req=%b want 1/1", busy, bus_if.bus_req); end
      go_to(n + 482);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done_n482: got done=%b busy=%b want 1/0", done, busy); end
      go_to(n + 490);
      checks++; if (done_q.size() - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_q.size() - d0); end
      checks++; if (rd_q.size() - r0 !== 160) begin errors++; $display("FAIL basic_rd_count: got %0d want 160", rd_q.size() - r0); end
      checks++; if (wr_q.size() - w0 !== 160) begin errors++; $display("FAIL basic_wr_count: got %0d want 160", wr_q.size() - w0); end
      for (int k = 0; k < 160; k++) begin
         checks++;
         if (oam[k] !== (8'(k) ^ 8'h5A)) begin errors++; $display("FAIL basic_oam[%0d]: got %h want %h", k, oam[k], 8'(k) ^ 8'h5A); end
      end
   endtask

   task automatic test_echo;
      logic [7:0] srcs [2];
      int n, r0;
      srcs[0] = 8'hE1;
      srcs[1] = 8'($urandom_range(0, 255));
      for (int t = 0; t < 2; t++) begin
         clear_oam(8'h00);
         r0 = rd_q.size();
         kick(srcs[t], n);
         go_to(n + 490);
         checks++; if (reg_rdata !== srcs[t]) begin errors++; $display("FAIL echo_rdata src=%h: got %h want %h", srcs[t], reg_rdata, srcs[t]); end
         checks++; if (rd_q.size() - r0 !== 160) begin errors++; $display("FAIL echo_rd_count src=%h: got %0d want 160", srcs[t], rd_q.size() - r0); end
         for (int k = 0; k < 160 && r0 + k < rd_q.size(); k++) begin
            checks++;
            if (rd_q[r0 + k] !== {eff_src(srcs[t]), 8'(k)}) begin errors++; $display("FAIL echo_addr src=%h k=%0d: got %h want %h", srcs[t], k, rd_q[r0 + k], {eff_src(srcs[t]), 8'(k)}); end
         end
         for (int k = 0; k < 160; k++) begin
            checks++;
            if (oam[k] !== exp_byte(srcs[t], k)) begin errors++; $display("FAIL echo_oam src=%h k=%0d: got %h want %h", srcs[t], k, oam[k], exp_byte(srcs[t], k)); end
         end
      end
   endtask

   task automatic test_stall;
      int n, d0, s0, cnt;
      clear_oam(8'h00);
      d0 = done_q.size(); s0 = strobe_q.size();
      kick(8'hC0, n);
      go_to(n + 19);
      gnt = 1'b0;
      go_to(n + 29);
      gnt = 1'b1;
      go_to(n + 500);
      cnt = 0;
      for (int j = s0; j < strobe_q.size(); j++)
         if (strobe_q[j] >= n + 20 && strobe_q[j] <= n + 29) cnt++;
      checks++; if (cnt !== 0) begin errors++; $display("FAIL stall_strobes: got %0d want 0", cnt); end
      checks++; if (done_q.size() - d0 !== 1) begin errors++; $display("FAIL stall_done_count: got %0d want 1", done_q.size() - d0); end
      else begin
         checks++; if (done_q[d0] !== n + 492) begin errors++; $display("FAIL stall_done_cycle: got N+%0d want N+492", done_q[d0] - n); end
      end
      for (int k = 0; k < 160; k++) begin
         checks++;
         if (oam[k] !== (8'(k) ^ 8'h5A)) begin errors++; $display("FAIL stall_oam[%0d]: got %h want %h", k, oam[k], 8'(k) ^ 8'h5A); end
      end
   endtask

   task automatic test_reset_mid;
      int n, d0;
      clear_oam(8'hEE);
      kick(8'hC0, n);
      go_to(n + 123);
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || bus_if.bus_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got busy=%b req=%b done=%b want 0/0/0", busy, bus_if.bus_req, done); end
      checks++; if (bus_if.m_rd !== 1'b0 || bus_if.m_wr !== 1'b0 || bus_if.m_addr !== 16'h0 || bus_if.m_wdata !== 8'h0) begin errors++; $display("FAIL rstmid_bus: got rd=%b wr=%b addr=%h wd=%h want zeros", bus_if.m_rd, bus_if.m_wr, bus_if.m_addr, bus_if.m_wdata); end
      checks++; if (reg_rdata !== 8'h00) begin errors++; $display("FAIL rstmid_rdata: got %h want 00", reg_rdata); end
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 160; k++) begin
         checks++;
         if (k < 40) begin
            if (oam[k] !== (8'(k) ^ 8'h5A)) begin errors++; $display("FAIL rstmid_kept[%0d]: got %h want %h", k, oam[k], 8'(k) ^ 8'h5A); end
         end else begin
            if (oam[k] !== 8'hEE) begin errors++; $display("FAIL rstmid_untouched[%0d]: got %h want ee", k, oam[k]); end
         end
      end
      d0 = done_q.size();
      kick(8'hC0, n);
      go_to(n + 490);
      checks++; if (done_q.size() - d0 !== 1 || (done_q.size() > d0 && done_q[d0] !== n + 482)) begin errors++; $display("FAIL rstmid_rerun_done: got count=%0d want 1 at N+482", done_q.size() - d0); end
      for (int k = 0; k < 160; k++) begin
         checks++;
         if (oam[k] !== (8'(k) ^ 8'h5A)) begin errors++; $display("FAIL rstmid_rerun[%0d]: got %h want %h", k, oam[k], 8'(k) ^ 8'h5A); end
      end
   endtask

   task automatic test_restart;
      int n, d0, exp_done;
      logic [7:0] exp_src;
      clear_oam(8'h00);
      d0 = done_q.size();
      kick(8'hC0, n);
      go_to(n + 62);
      reg_wdata = 8'hD0;
      reg_wr    = 1'b1;
      @(negedge clk);
      reg_wr    = 1'b0;
      go_to(n + 570);
`ifdef OAM_DMA_RESTART_EN
      exp_done = n + 62 + 482;
      exp_src  = 8'hD0;
`else
      exp_done = n + 482;
      exp_src  = 8'hC0;
`endif
      checks++; if (done_q.size() - d0 !== 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", done_q.size() - d0); end
      else begin
         checks++; if (done_q[d0] !== exp_done) begin errors++; $display("FAIL restart_done_cycle: got N+%0d want N+%0d", done_q[d0] - n, exp_done - n); end
      end
      checks++; if (reg_rdata !== 8'hD0) begin errors++; $display("FAIL restart_rdata: got %h want d0", reg_rdata); end
      for (int k = 0; k < 160; k++) begin
         checks++;
         if (oam[k] !== exp_byte(exp_src, k)) begin errors++; $display("FAIL restart_oam[%0d]: got %h want %h", k, oam[k], exp_byte(exp_src, k)); end
      end
   endtask

   task automatic test_boundary;
      int n, d0, exp_cnt;
      logic [7:0] exp_src;
      logic exp_busy;
      clear_oam(8'h00);
      d0 = done_q.size();
      kick(8'hC0, n);
      go_to(n + 481);
      reg_wdata = 8'hC1;
      reg_wr    = 1'b1;
      @(negedge clk);
      reg_wr    = 1'b0;
`ifdef OAM_DMA_RESTART_EN
      exp_busy = 1'b1; exp_cnt = 2; exp_src = 8'hC1;
`else
      exp_busy = 1'b0; exp_cnt = 1; exp_src = 8'hC0;
`endif
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL boundary_done: got %b want 1", done); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL boundary_busy: got %b want %b", busy, exp_busy); end
      go_to(n + 980);
      checks++; if (done_q.size() - d0 !== exp_cnt) begin errors++; $display("FAIL boundary_done_count: got %0d want %0d", done_q.size() - d0, exp_cnt); end
      else if (exp_cnt == 2) begin
         checks++; if (done_q[d0 + 1] !== n + 481 + 482) begin errors++; $display("FAIL boundary_second_done: got N+%0d want N+963", done_q[d0 + 1] - n); end
      end
      checks++; if (reg_rdata !== 8'hC1) begin errors++; $display("FAIL boundary_rdata: got %h want c1", reg_rdata); end
      for (int k = 0; k < 160; k++) begin
         checks++;
         if (oam[k] !== exp_byte(exp_src, k)) begin errors++; $display("FAIL boundary_oam[%0d]: got %h want %h", k, oam[k], exp_byte(exp_src, k)); end
      end
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
      for (int k = 0; k < 160; k++) mem[16'hC000 + k] = 8'(k) ^ 8'h5A;
      test_reset();
      test_basic();
      test_echo();
      test_stall();
      test_reset_mid();
      test_restart();
      test_boundary();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
